// File: rtl/mult_sched_pkg.sv
// Shared constants for the multiplier scheduler: FSM encoding, operand widths
// and the default done timeout.
package mult_sched_pkg;

    localparam int unsigned AW         = 7;
    localparam int unsigned BW         = 5;
    localparam int unsigned PW         = 11;
    localparam int unsigned DefTimeout = 64;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLaunch = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

endpackage

// File: rtl/mult_sched_rr_pick.sv
// Combinational round-robin search: first set request at or above rr_i,
// wrapping around modulo NREQ.
module mult_sched_rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_i,
    output logic            found_o,
    output logic [IDW-1:0]  idx_o
);

    int unsigned     cand;
    logic [NREQ-1:0] shifted;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        shifted = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand    = (32'(rr_i) + k) % NREQ;
            shifted = req_i >> cand;
            if (!found_o && shifted[0]) begin
                found_o = 1'b1;
                idx_o   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one shift-add multiplier among NREQ requesters,
// with a done timeout that turns a hung job into an error response.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = DefTimeout,
    parameter int unsigned IDW     = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] a_in,
    input  logic [NREQ*BW-1:0] b_in,
    output logic [NREQ-1:0]    ack,
    output logic               res_valid,
    output logic [PW-1:0]      res_data,
    output logic [IDW-1:0]     res_id,
    output logic               res_err,
    output logic               busy,
    output logic               mul_init,
    output logic [AW-1:0]      mul_A,
    output logic [BW-1:0]      mul_B,
    input  logic               mul_done,
    input  logic [PW-1:0]      mul_pp
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  sel_q, sel_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   mul_a_q, mul_a_d;
    logic [BW-1:0]   mul_b_q, mul_b_d;
    logic            mul_init_q, mul_init_d;
    logic            res_valid_q, res_valid_d;
    logic [PW-1:0]   res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            res_err_q, res_err_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;

    mult_sched_rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_rr_pick (
        .req_i  (req),
        .rr_i   (rr_q),
        .found_o(pick_found),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_init_d  = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        ack_d       = '0;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    sel_d      = pick_idx;
                    mul_a_d    = AW'(a_in >> (32'(pick_idx) * AW));
                    mul_b_d    = BW'(b_in >> (32'(pick_idx) * BW));
                    mul_init_d = 1'b1;
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CW'(1);
                // done is stale during the first WAIT cycle; done beats timeout
                if (cnt_q != '0 && mul_done) begin
                    res_data_d  = mul_pp;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    res_id_d    = sel_q;
                    ack_d       = NREQ'(1) << sel_q;
                    state_d     = StResp;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    res_id_d    = sel_q;
                    ack_d       = NREQ'(1) << sel_q;
                    state_d     = StResp;
                end
            end
            default: begin
                if (32'(sel_q) >= NREQ - 1) begin
                    rr_d = '0;
                end else begin
                    rr_d = sel_q + IDW'(1);
                end
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_init_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_init_q  <= mul_init_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            ack_q       <= ack_d;
        end
    end

    assign ack       = ack_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != StIdle);
    assign mul_init  = mul_init_q;
    assign mul_A     = mul_a_q;
    assign mul_B     = mul_b_q;

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: behavioural requesters and multiplier, with a
// job-level scoreboard predicting grant order, product, error and latency.
module tb_mult_sched;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req  = '0;
    logic [NREQ*7-1:0] a_in = '0;
    logic [NREQ*5-1:0] b_in = '0;
    logic [NREQ-1:0]   ack;
    logic              res_valid;
    logic [10:0]       res_data;
    logic [IDW-1:0]    res_id;
    logic              res_err;
    logic              busy;
    logic              mul_init;
    logic [6:0]        mul_A;
    logic [4:0]        mul_B;
    logic              mul_done;
    logic [10:0]       mul_pp;

    mult_sched #(
        .NREQ   (NREQ),
        .TIMEOUT(TIMEOUT),
        .IDW    (IDW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .ack      (ack),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_id   (res_id),
        .res_err  (res_err),
        .busy     (busy),
        .mul_init (mul_init),
        .mul_A    (mul_A),
        .mul_B    (mul_B),
        .mul_done (mul_done),
        .mul_pp   (mul_pp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Multiplier model: 0 = done D cycles after init, 1 = never done,
    // 2 = done asserted immediately and held (stale-done case).
    int mul_mode = 0;
    int mul_dly  = 12;
    int mcnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt     <= 0;
            mul_done <= 1'b0;
            mul_pp   <= '0;
        end else if (mul_init) begin
            mcnt <= (mul_mode == 0) ? mul_dly : 0;
            if (mul_mode == 2) begin
                mul_done <= 1'b1;
                mul_pp   <= 11'(int'(mul_A) * int'(mul_B));
            end else begin
                mul_done <= 1'b0;
            end
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt     <= 0;
            mul_done <= 1'b1;
            mul_pp   <= 11'(int'(mul_A) * int'(mul_B));
        end
    end

    // Requesters: pend[i] = jobs still wanted; operands held until ack.
    int            pend[NREQ];
    int            op_a[NREQ];
    int            op_b[NREQ];
    logic [NREQ-1:0] ack_seen = '0;
    bit            rand_ops = 1'b0;

    task automatic drive_pins();
        for (int i = 0; i < NREQ; i++) begin
            req[i]          = (pend[i] > 0);
            a_in[i*7 +: 7]  = 7'(op_a[i]);
            b_in[i*5 +: 5]  = 5'(op_b[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_seen[i]) begin
                if (pend[i] > 0) pend[i]--;
                if (rand_ops) begin
                    op_a[i] = int'($urandom_range(0, 127));
                    op_b[i] = int'($urandom_range(0, 31));
                end
            end
        end
        ack_seen = ack;
        drive_pins();
    endtask

    function automatic int pend_sum();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += pend[i];
        return s;
    endfunction

    task automatic wait_all(input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if (pend_sum() == 0 && ack_seen == '0 && !busy) break;
        end
        check_eq("drain_pending", pend_sum(), 0);
    endtask

    // Scoreboard state
    logic [NREQ-1:0] req_s;
    int  rr_m      = 0;
    bit  exp_valid = 1'b0;
    int  exp_id, exp_data, exp_err, exp_lat;
    int  lat_cnt   = 0;
    int  gap_cnt   = 100;
    int  last_hold = 0;
    int  mon_id;
    int  served[$];
    int  gaps[$];

    always @(posedge clk) req_s <= req;

    function automatic int pick_model(input logic [NREQ-1:0] r, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            lat_cnt++;
            gap_cnt++;
            if (mul_init) begin
                // Selection happened on the previous rising edge.
                mon_id = pick_model(req_s, rr_m);
                check_eq("grant_has_req", int'(mon_id >= 0), 1);
                check_eq("grant_overlap", int'(exp_valid), 0);
                check_eq("grant_gap_min", int'(gap_cnt >= 2), 1);
                check_eq("grant_busy", int'(busy), 1);
                gaps.push_back(gap_cnt);
                exp_id = (mon_id < 0) ? 0 : mon_id;
                check_eq("mul_A", int'(mul_A), op_a[exp_id]);
                check_eq("mul_B", int'(mul_B), op_b[exp_id]);
                if (mul_mode == 1 || (mul_mode == 0 && mul_dly + 2 > TIMEOUT + 1)) begin
                    exp_err  = 1;
                    exp_data = 0;
                    exp_lat  = TIMEOUT + 1;
                end else begin
                    exp_err  = 0;
                    exp_data = (op_a[exp_id] * op_b[exp_id]) % 2048;
                    exp_lat  = (mul_mode == 2) ? 3 : mul_dly + 2;
                end
                exp_valid = 1'b1;
                lat_cnt   = 0;
            end
            if (res_valid) begin
                check_eq("res_expected", int'(exp_valid), 1);
                check_eq("res_id", int'(res_id), exp_id);
                check_eq("res_data", int'(res_data), exp_data);
                check_eq("res_err", int'(res_err), exp_err);
                check_eq("res_ack", int'(ack), 1 << exp_id);
                check_eq("res_latency", lat_cnt, exp_lat);
                served.push_back(exp_id);
                rr_m      = (exp_id + 1) % NREQ;
                last_hold = (exp_data << 4) | (exp_id << 1) | exp_err;
                exp_valid = 1'b0;
                gap_cnt   = 0;
            end else begin
                check_eq("ack_idle", int'(ack), 0);
                check_eq("res_hold", int'({res_data, res_id, res_err}), last_hold);
            end
        end
    end

    task automatic check_outs_zero(input string tag);
        check_eq({tag, "_res"}, int'({ack, res_valid, res_data, res_id, res_err}), 0);
        check_eq({tag, "_mul"}, int'({busy, mul_init, mul_A, mul_B}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs_zero("reset_outs");
        exp_valid = 1'b0;
        rr_m      = 0;
        gap_cnt   = 100;
        last_hold = 0;
        ack_seen  = '0;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0;
            op_a[i] = 0;
            op_b[i] = 0;
        end
        drive_pins();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_reqs();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2 check_outs_zero("init_reset");
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Single request
        mul_mode = 0; mul_dly = 12;
        pend[0] = 1; op_a[0] = 5; op_b[0] = 3;
        drive_pins();
        served.delete();
        wait_all(200);
        check_eq("single_data", int'(res_data), 15);
        check_eq("single_count", served.size(), 1);

        // Round-robin from a fresh pointer
        do_reset();
        served.delete(); gaps.delete();
        pend[0] = 2; pend[1] = 1; pend[2] = 1;
        op_a[0] = 2; op_a[1] = 3; op_a[2] = 4;
        op_b[0] = 1; op_b[1] = 1; op_b[2] = 1;
        mul_dly = 5;
        drive_pins();
        wait_all(300);
        check_eq("rr_count", served.size(), 4);
        if (served.size() == 4) begin
            check_eq("rr_order0", served[0], 0);
            check_eq("rr_order1", served[1], 1);
            check_eq("rr_order2", served[2], 2);
            check_eq("rr_order3", served[3], 0);
            check_eq("rr_gap1", gaps[1], 2);
            check_eq("rr_gap2", gaps[2], 2);
            check_eq("rr_gap3", gaps[3], 2);
        end
        check_eq("rr_last_data", int'(res_data), 2);

        // Timeout then a normal job
        mul_mode = 1;
        pend[0] = 1; op_a[0] = 9; op_b[0] = 9;
        drive_pins();
        wait_all(300);
        check_eq("to_err", int'(res_err), 1);
        check_eq("to_data", int'(res_data), 0);
        mul_mode = 0; mul_dly = 7;
        pend[0] = 1;
        drive_pins();
        wait_all(300);
        check_eq("after_to_data", int'(res_data), 81);
        check_eq("after_to_err", int'(res_err), 0);

        // Stale done held across jobs
        mul_mode = 2;
        pend[1] = 2; op_a[1] = 6; op_b[1] = 7;
        drive_pins();
        wait_all(300);
        check_eq("stale_data", int'(res_data), 42);

        // Reset during WAIT
        mul_mode = 0; mul_dly = 20;
        pend[0] = 1; op_a[0] = 10; op_b[0] = 10;
        drive_pins();
        for (int c = 0; c < 50; c++) begin
            step();
            if (mul_init) break;
        end
        repeat (4) step();
        check_eq("rwait_busy", int'(busy), 1);
        served.delete();
        do_reset();
        check_eq("rwait_req_held", int'(req[0]), 1);
        wait_all(300);
        check_eq("rwait_served", served.size(), 1);
        check_eq("rwait_data", int'(res_data), 100);

        // Product wrap
        mul_dly = 3;
        pend[2] = 1; op_a[2] = 127; op_b[2] = 31;
        drive_pins();
        wait_all(300);
        check_eq("wrap_data", int'(res_data), 1889);

        // done in the timeout cycle wins; one cycle later it is too late
        mul_dly = TIMEOUT - 1;
        pend[1] = 1; op_a[1] = 11; op_b[1] = 13;
        drive_pins();
        wait_all(400);
        check_eq("edge_done_err", int'(res_err), 0);
        check_eq("edge_done_data", int'(res_data), 143);
        mul_dly = TIMEOUT;
        pend[1] = 1;
        drive_pins();
        wait_all(400);
        check_eq("edge_to_err", int'(res_err), 1);

        // Randomised traffic
        rand_ops = 1'b1;
        for (int s = 0; s < 1500; s++) begin
            case ($urandom_range(0, 15))
                0:       mul_mode = 1;
                1, 2:    mul_mode = 2;
                default: mul_mode = 0;
            endcase
            mul_dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70))
                                                  : int'($urandom_range(1, 15));
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] == 0 && ack_seen[i] == 1'b0 && $urandom_range(0, 7) == 0) begin
                    pend[i] = int'($urandom_range(1, 3));
                    op_a[i] = int'($urandom_range(0, 127));
                    op_b[i] = int'($urandom_range(0, 31));
                end
            end
            drive_pins();
        end
        mul_mode = 0; mul_dly = 4;
        wait_all(3000);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
